// File: rtl/decode_pkg.sv
// decode_pkg: shared state encoding, dest-select codes and default widths for the decode stage.
package decode_pkg;
  localparam int DATA_W_D = 16;
  localparam int NREG_D = 8;
  localparam int RA_W_D = 3;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, HALTED = 2'd2} state_t;
  localparam logic [1:0] WS_RT = 2'd0;
  localparam logic [1:0] WS_RS = 2'd1;
  localparam logic [1:0] WS_LAST = 2'd2;
  localparam logic [1:0] WS_RD = 2'd3;
endpackage

// File: rtl/regfile_bypass.sv
// regfile_bypass: NREG x DATA_W register file, two read ports, one write port with write-through bypass.
module regfile_bypass import decode_pkg::*; #(
  parameter int DATA_W = DATA_W_D,
  parameter int NREG = NREG_D,
  parameter int RA_W = RA_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RA_W-1:0]   wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [RA_W-1:0]   ra1,
  input  logic [RA_W-1:0]   ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  logic [DATA_W-1:0] mem [NREG];
  logic wv;
  // out-of-range write indices are dropped, so they neither store nor bypass
  assign wv = we && (32'(wa) < 32'(NREG));
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (wv) mem[wa] <= wd;
  assign rd1 = (wv && wa == ra1) ? wd : mem[ra1];
  assign rd2 = (wv && wa == ra2) ? wd : mem[ra2];
endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: instruction decode with register read, load-use stall, ID/EX pipeline register and halt FSM.
module decode_pipe import decode_pkg::*; #(
  parameter int DATA_W = DATA_W_D,
  parameter int NREG = NREG_D,
  parameter int RA_W = RA_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [15:0]       instr,
  input  logic              ctl_wr_en,
  input  logic              ctl_mem_rd,
  input  logic              ctl_sext,
  input  logic              ctl_halt,
  input  logic              ctl_use_rs,
  input  logic              ctl_use_rt,
  input  logic [1:0]        ctl_wr_sel,
  output logic              id_ready,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_num,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_r1,
  output logic [DATA_W-1:0] ex_r2,
  output logic [DATA_W-1:0] ex_i5,
  output logic [DATA_W-1:0] ex_i8,
  output logic [DATA_W-1:0] ex_d,
  output logic [RA_W-1:0]   ex_wr_num,
  output logic              ex_wr_en,
  output logic              ex_mem_rd,
  output logic              ex_halt,
  output logic              halted
);
  state_t state, state_n;
  logic [RA_W-1:0] rs, rt, wr_num;
  logic [DATA_W-1:0] rd1, rd2;
  logic hazard, load;
  assign rs = RA_W'(instr[10:8]);
  assign rt = RA_W'(instr[7:5]);
  assign wr_num = ctl_wr_sel == WS_RT ? rt :
                  ctl_wr_sel == WS_RS ? rs :
                  ctl_wr_sel == WS_LAST ? RA_W'(NREG - 1) : RA_W'(instr[4:2]);
  assign hazard = ex_valid & ex_mem_rd & ex_wr_en &
                  ((ctl_use_rs & rs == ex_wr_num) | (ctl_use_rt & rt == ex_wr_num));
  assign id_ready = state == RUN & ~hazard & ~(ex_valid & ~ex_ready);
  assign load = id_valid & id_ready & ~flush;
  assign halted = state == HALTED;
  regfile_bypass #(.DATA_W(DATA_W), .NREG(NREG), .RA_W(RA_W)) u_rf (
    .clk(clk), .rst(rst), .we(wb_en), .wa(wb_num), .wd(wb_data),
    .ra1(rs), .ra2(rt), .rd1(rd1), .rd2(rd2)
  );
  // a halt leaving ID/EX wins over everything; flush only cancels a stall
  always_comb begin
    state_n = state;
    state_n = state == HALTED ? HALTED :
              (ex_valid & ex_ready & ex_halt) ? HALTED :
              (flush | state == STALL) ? RUN :
              (hazard & ex_ready) ? STALL : RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_valid <= 1'b0;
      ex_r1 <= '0;
      ex_r2 <= '0;
      ex_i5 <= '0;
      ex_i8 <= '0;
      ex_d <= '0;
      ex_wr_num <= '0;
      ex_wr_en <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_halt <= 1'b0;
    end else if (flush) ex_valid <= 1'b0;
    else if (load) begin
      ex_valid <= 1'b1;
      ex_r1 <= rd1;
      ex_r2 <= rd2;
      ex_i5 <= {{(DATA_W-5){ctl_sext & instr[4]}}, instr[4:0]};
      ex_i8 <= {{(DATA_W-8){ctl_sext & instr[7]}}, instr[7:0]};
      ex_d <= {{(DATA_W-11){ctl_sext & instr[10]}}, instr[10:0]};
      ex_wr_num <= wr_num;
      ex_wr_en <= ctl_wr_en;
      ex_mem_rd <= ctl_mem_rd;
      ex_halt <= ctl_halt;
    end else if (ex_ready) ex_valid <= 1'b0;
endmodule
